// File: rtl/vc_plane_scheduler_if.sv
// Plane-select bundle between the scheduler and the per-VC pipelines it time-multiplexes.
// The master (scheduler) consumes request/lock status and drives the one-hot plane selector.
interface vc_plane_scheduler_if #(
    parameter int VC   = 4,
    parameter int VC_W = $clog2(VC)
);
    logic [VC-1:0]   vc_req;
    logic [VC-1:0]   vc_locked;
    logic [VC:0]     VCPlaneSelector;
    logic [VC_W-1:0] active_vc;
    logic            plane_valid;
    logic            switch_pulse;

    modport master (
        input  vc_req, vc_locked,
        output VCPlaneSelector, active_vc, plane_valid, switch_pulse
    );

    modport slave (
        output vc_req, vc_locked,
        input  VCPlaneSelector, active_vc, plane_valid, switch_pulse
    );
endinterface

// File: rtl/vc_plane_scheduler.sv
// Work-conserving, packet-atomic, quantum-bounded round-robin owner of the shared crossbar.
// Request-to-grant is 1 cycle from idle; leaving a plane always costs one idle (GAP) cycle.
module vc_plane_scheduler #(
    parameter int VC      = 4,
    parameter int VC_W    = $clog2(VC),
    parameter int QUANTUM = 8,
    parameter int QW      = $clog2(QUANTUM+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    vc_plane_scheduler_if.master  vif
);

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    localparam logic [QW-1:0] QMAX = QW'(QUANTUM);

    state_t          state, state_nxt;
    logic [QW-1:0]   cnt, cnt_nxt;
    logic [VC_W-1:0] act, act_nxt, pick;
    logic [VC:0]     sel, sel_nxt;
    logic [VC-1:0]   grant_oh;
    logic            pulse, pulse_nxt;
    logic            pv;
    logic            any_req, other_req, quantum_up;

    // Round-robin search starting just after the current owner; the owner itself is tried last.
    always_comb begin : pick_logic
        int idx;
        idx  = 0;
        pick = act;
        for (int i = VC; i >= 1; i--) begin
            idx = (int'(act) + i) % VC;
            if (vif.vc_req[idx]) pick = VC_W'(idx);
        end
    end

    assign any_req    = |vif.vc_req;
    assign other_req  = |(vif.vc_req & ~({{(VC-1){1'b0}}, 1'b1} << act));
    assign quantum_up = (cnt == QMAX);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        act_nxt   = act;
        pulse_nxt = 1'b0;
        case (state)
            HOLD: begin
                // Lock wins over fairness; the counter just saturates until the tail passes.
                if (vif.vc_locked[act]) begin
                    cnt_nxt = quantum_up ? QMAX : cnt + QW'(1);
                end else if (!vif.vc_req[act]) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (quantum_up && other_req) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else if (quantum_up) begin
                    cnt_nxt = QW'(1);
                end else begin
                    cnt_nxt = cnt + QW'(1);
                end
            end
            default: begin
                if (any_req) begin
                    state_nxt = HOLD;
                    act_nxt   = pick;
                    cnt_nxt   = QW'(1);
                    pulse_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
        endcase
        grant_oh = {{(VC-1){1'b0}}, 1'b1} << act_nxt;
        sel_nxt  = (state_nxt == HOLD) ? {1'b0, grant_oh} : {1'b1, {VC{1'b0}}};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            act   <= VC_W'(VC-1);
            sel   <= {1'b1, {VC{1'b0}}};
            pv    <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            act   <= act_nxt;
            sel   <= sel_nxt;
            pv    <= (state_nxt == HOLD);
            pulse <= pulse_nxt;
        end
    end

    assign vif.VCPlaneSelector = sel;
    assign vif.active_vc       = act;
    assign vif.plane_valid     = pv;
    assign vif.switch_pulse    = pulse;

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// Scoreboard bench: a plane-ownership model predicts each cycle's outputs; a negedge monitor compares.
module tb_vc_plane_scheduler;
    localparam int VC   = 4;
    localparam int VC_W = 2;
    localparam int Q    = 4;

    typedef struct packed {
        logic [VC:0]     sel;
        logic [VC_W-1:0] act;
        logic            pv;
        logic            pulse;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vc_plane_scheduler_if #(.VC(VC)) vif ();
    vc_plane_scheduler #(.VC(VC), .QUANTUM(Q)) dut (.clk(clk), .rst(rst), .vif(vif));

    obs_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Model: which plane owns the switch (-1 = nobody), who owned it last, cycles into its turn.
    int m_grant = -1;
    int m_last  = VC-1;
    int m_turn  = 0;
    bit m_pulse = 1'b0;

    function automatic obs_t rst_obs();
        obs_t o;
        o.sel     = '0;
        o.sel[VC] = 1'b1;
        o.act     = VC_W'(VC-1);
        o.pv      = 1'b0;
        o.pulse   = 1'b0;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.sel = '0;
        if (m_grant >= 0) o.sel[m_grant] = 1'b1;
        else              o.sel[VC] = 1'b1;
        o.act   = VC_W'(m_last);
        o.pv    = (m_grant >= 0);
        o.pulse = m_pulse;
        return o;
    endfunction

    task automatic model_step(input logic [VC-1:0] req, input logic [VC-1:0] lk);
        logic [VC-1:0] others;
        int found;
        m_pulse = 1'b0;
        if (m_grant < 0) begin
            found = -1;
            for (int k = 1; k <= VC; k++)
                if (found < 0 && req[(m_last + k) % VC]) found = (m_last + k) % VC;
            if (found >= 0) begin
                m_grant = found;
                m_last  = found;
                m_turn  = 1;
                m_pulse = 1'b1;
            end
        end else begin
            others = req;
            others[m_grant] = 1'b0;
            if (lk[m_grant])                    m_turn = (m_turn < Q) ? m_turn + 1 : Q;
            else if (!req[m_grant])             m_grant = -1;
            else if (m_turn == Q && others != 0) m_grant = -1;
            else if (m_turn == Q)               m_turn = 1;
            else                                m_turn = m_turn + 1;
        end
    endtask

    task automatic cmp(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got sel=%b act=%0d pv=%b pulse=%b want sel=%b act=%0d pv=%b pulse=%b",
                     name, $time, got.sel, got.act, got.pv, got.pulse,
                     exp.sel, exp.act, exp.pv, exp.pulse);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.sel   = vif.VCPlaneSelector;
        o.act   = vif.active_vc;
        o.pv    = vif.plane_valid;
        o.pulse = vif.switch_pulse;
        return o;
    endfunction

    // Model/scoreboard producer
    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_grant = -1;
            m_last  = VC-1;
            m_turn  = 0;
            m_pulse = 1'b0;
            sbq.delete();
        end else begin
            model_step(vif.vc_req, vif.vc_locked);
            sbq.push_back(model_obs());
        end
    end

    // Monitor
    initial forever begin
        obs_t got;
        @(negedge clk);
        got = sample();
        total++;
        if (!$onehot(got.sel)) begin
            bad++;
            $display("FAIL onehot t=%0t got sel=%b want exactly one bit", $time, got.sel);
        end
        total++;
        if (got.pv !== ~got.sel[VC]) begin
            bad++;
            $display("FAIL pv_vs_sel t=%0t got pv=%b want %b", $time, got.pv, ~got.sel[VC]);
        end
        if (!rst) begin
            cmp("reset", got, rst_obs());
        end else if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL underflow t=%0t got output with no expectation queued", $time);
        end else begin
            cmp("cycle", got, sbq.pop_front());
        end
    end

    task automatic drive(input logic [VC-1:0] r, input logic [VC-1:0] l, input int n);
        vif.vc_req    = r;
        vif.vc_locked = l;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [VC-1:0] r, l;
        vif.vc_req    = '0;
        vif.vc_locked = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        drive(4'b0000, 4'b0000, 2);
        drive(4'b0001, 4'b0000, 3);
        drive(4'b0000, 4'b0000, 3);
        drive(4'b1111, 4'b0000, 30);
        drive(4'b0000, 4'b0000, 3);
        drive(4'b0010, 4'b0000, 2);
        drive(4'b1111, 4'b0010, 10);
        drive(4'b1111, 4'b0000, 12);
        drive(4'b0000, 4'b0000, 3);
        drive(4'b0100, 4'b0000, 20);
        drive(4'b1000, 4'b0000, 4);
        drive(4'b1100, 4'b0100, 3);
        drive(4'b1000, 4'b0000, 3);
        drive(4'b0000, 4'b0000, 3);
        drive(4'b0011, 4'b0000, 6);

        // Asynchronous reset in the middle of a VC2 hold
        drive(4'b0000, 4'b0000, 3);
        drive(4'b0100, 4'b0100, 3);
        #2 rst = 1'b0;
        #1 cmp("async_rst", sample(), rst_obs());
        @(negedge clk);
        @(negedge clk);
        vif.vc_locked = '0;
        #2 rst = 1'b1;
        drive(4'b0100, 4'b0000, 5);

        repeat (400) begin
            r = VC'($urandom_range(0, 15));
            l = ($urandom_range(0, 2) == 0) ? (r & VC'($urandom_range(0, 15))) : '0;
            drive(r, l, $urandom_range(1, 8));
        end

        drive(4'b0000, 4'b0000, 3);
        @(posedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vc_plane_scheduler.md
Name: vc_plane_scheduler

Overview:
- Time-multiplexes the shared crossbar/MuxSwitch between the per-VC router pipelines by driving the one-hot VCPlaneSelector consumed by VCDemux, VCMux and each pipeline.
- Replaces the free-running plane rotation with a work-conserving, packet-atomic, quantum-bounded round-robin scheduler.
- Never switches away from a plane that is mid-packet.

Parameters:
- VC, 4: number of virtual-channel planes; must be at least 2.
- VC_W, $clog2(VC): width of the VC index.
- QUANTUM, 8: maximum cycles a plane keeps the switch while other planes request; range 1..255.
- QW, $clog2(QUANTUM+1): width of the quantum counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- vc_req  in  VC  bit v high: plane v has a flit pending at any input.
- vc_locked  in  VC  bit v high: plane v is mid-packet, i.e. head transferred and tail not yet transferred.
- VCPlaneSelector  out  VC+1  one-hot. Bit v grants plane v; bit VC is the idle/no-plane code.
- active_vc  out  VC_W  index of the granted plane; holds the last granted index when idle.
- plane_valid  out  1  high when a plane (bits VC-1..0) is granted.
- switch_pulse  out  1  one-cycle pulse on the cycle a new plane grant first appears.

Behaviour:
- All outputs are registered.
- Reset values:
  - VCPlaneSelector = 1<<VC.
  - active_vc = VC-1, so the first grant after reset goes to VC0.
  - plane_valid = 0, switch_pulse = 0, quantum counter = 0, state = IDLE.
- Reset asserted mid-packet abandons the grant immediately and asynchronously. The surrounding pipelines are reset by the same rst.
- Round-robin pick: the first v with vc_req[v]=1, searching from (active_vc+1) mod VC upward with wrap.
- FSM states are IDLE, HOLD and GAP.
- IDLE:
  - Selector = idle code.
  - Any vc_req: grant pick on the next edge → HOLD, switch_pulse=1, counter=1. Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE.
- HOLD (plane g = active_vc granted):
  - Counter increments each cycle and saturates at QUANTUM.
  - If vc_locked[g]=1: stay, regardless of vc_req or quantum. Wormhole atomicity wins over fairness.
  - Else if vc_req[g]=0: → GAP.
  - Else if counter==QUANTUM and another plane requests: → GAP.
  - Else if counter==QUANTUM and no other plane requests: stay, counter reloads to 1, no bubble, no switch_pulse.
  - Else: stay.
- GAP:
  - Exactly one cycle with selector = idle code. This lets VCMux/MuxSwitch reservations and ready paths settle.
  - active_vc is unchanged.
  - Next edge: any vc_req → HOLD on pick with switch_pulse=1. Otherwise → IDLE.
  - In GAP the pick excludes nothing: if only the previous plane still requests, it is re-granted.
- Exactly one bit of VCPlaneSelector is high in every cycle; the bench asserts this.
- plane_valid == ~VCPlaneSelector[VC].
- active_vc wraps from VC-1 to 0.
- Simultaneous events:
  - Locked deasserting on the same cycle the quantum expires → leave (GAP) that edge.
  - vc_req of the granted plane dropping while locked → stay until unlocked.
- Fairness bound: a requesting plane waits at most (VC-1)·(QUANTUM+1+L) cycles, where L is the longest locked extension beyond quantum.

Test Plan:
- Reset then vc_req=4'b0001 at cycle 2 → VCPlaneSelector=5'b00001 and switch_pulse=1 at cycle 3; idle code 5'b10000 until then.
- vc_req=4'b1111 held, vc_locked=0, QUANTUM=4 → grants VC0,1,2,3,0, each 4 cycles, separated by 1-cycle GAP (idle code); switch_pulse once per grant.
- VC1 granted, vc_locked[1]=1 for 10 cycles, vc_req=4'b1111, QUANTUM=4 → VC1 held 10 cycles; GAP on the cycle after lock clears; then VC2 granted.
- Only vc_req[2]=1 for 20 cycles, QUANTUM=4 → selector stays 5'b00100 throughout; no GAP; switch_pulse only once.
- VC3 granted, vc_req drops to 0 with lock clear → GAP, then IDLE. Then vc_req=4'b0011 → VC0 granted (wrap from 3).
- rst low asynchronously mid-HOLD on VC2 → outputs return to reset values before the next edge. After release with vc_req=4'b0100 → VC2 granted 1 cycle later.
